// File: rtl/segway_pkg.sv
`default_nettype none
// ============================================================================
// Package     : segway_pkg
// Description : Shared types and constants for the A2D load-cell interface.
// Revision    : 1.0 - initial release
// ============================================================================
package segway_pkg;

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} a2d_state_t;

    typedef enum logic [1:0] {RR_LFT, RR_RGHT, RR_STEER, RR_BATT} rr_idx_t;

    localparam int SPI_FRAME_BITS = 16;

    // ADC command word: channel number sits in bits [13:11]
    function automatic logic [SPI_FRAME_BITS-1:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_mnrch.sv
`default_nettype none
// ============================================================================
// Module      : spi_mnrch
// Description : 16-bit mode-3 SPI master, SCLK = clk/32, one frame per wrt.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mnrch
    import segway_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrt,
    input  logic [SPI_FRAME_BITS-1:0] wt_data,
    output logic                      done,
    output logic [SPI_FRAME_BITS-1:0] rd_data,
    output logic                      SS_n,
    output logic                      SCLK,
    output logic                      MOSI,
    input  logic                      MISO
);

    localparam logic [4:0] c_DIV_PRESET = 5'b10111;
    localparam logic [4:0] c_DIV_RISE   = 5'b01111;
    localparam logic [4:0] c_DIV_FALL   = 5'b11111;
    localparam logic [4:0] c_DIV_DONE   = 5'd6;
    localparam logic [4:0] c_LAST_BIT   = 5'(SPI_FRAME_BITS);
    localparam logic [4:0] c_TAIL       = 5'(SPI_FRAME_BITS + 1);

    logic                      r_active;
    logic                      r_sclk;
    logic [4:0]                r_div;
    logic [4:0]                r_fall_cnt;
    logic [SPI_FRAME_BITS-1:0] r_shreg;
    logic                      r_miso_smpl;

    logic w_tail;
    logic w_fall;
    logic w_shft;
    logic w_smpl;
    logic w_done;

    // Fall events: the first is the leading edge (no shift), the 17th is a
    // phantom fall with SCLK parked high that captures the last MISO bit.
    assign w_tail = (r_fall_cnt == c_TAIL);
    assign w_fall = r_active && (r_div == c_DIV_FALL) && !w_tail;
    assign w_shft = w_fall && (r_fall_cnt != 5'd0);
    assign w_smpl = r_active && (r_div == c_DIV_RISE) && !w_tail;
    // SS_n stays low until the frame has spanned 528 clk
    assign w_done = r_active && w_tail && (r_div == c_DIV_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active    <= 1'b0;
            r_sclk      <= 1'b1;
            r_div       <= c_DIV_PRESET;
            r_fall_cnt  <= 5'd0;
            r_shreg     <= '0;
            r_miso_smpl <= 1'b0;
        end else if (!r_active) begin
            if (wrt) begin
                r_active   <= 1'b1;
                r_sclk     <= 1'b1;
                r_div      <= c_DIV_PRESET;
                r_fall_cnt <= 5'd0;
                r_shreg    <= wt_data;
            end
        end else begin
            r_div <= r_div + 5'd1;
            if (w_smpl) begin
                r_miso_smpl <= MISO;
                r_sclk      <= 1'b1;
            end
            if (w_fall) begin
                r_fall_cnt <= r_fall_cnt + 5'd1;
                if (r_fall_cnt != c_LAST_BIT) begin
                    r_sclk <= 1'b0;
                end
            end
            if (w_shft) begin
                r_shreg <= {r_shreg[SPI_FRAME_BITS-2:0], r_miso_smpl};
            end
            if (w_done) begin
                r_active <= 1'b0;
            end
        end
    end

    assign done    = w_done;
    assign rd_data = r_shreg;
    assign SS_n    = ~r_active;
    assign SCLK    = r_sclk;
    assign MOSI    = r_active & r_shreg[SPI_FRAME_BITS-1];

endmodule
`default_nettype wire

// File: rtl/a2d_ld_intf.sv
`default_nettype none
// ============================================================================
// Module      : a2d_ld_intf
// Description : Round-robin ADC reader publishing four 12-bit channel results.
// Revision    : 1.0 - initial release
// ============================================================================
module a2d_ld_intf
    import segway_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        vld
);

    a2d_state_t r_state;
    a2d_state_t w_state_nxt;
    rr_idx_t    r_rr;

    logic [11:0] r_lft_ld;
    logic [11:0] r_rght_ld;
    logic [11:0] r_steer_pot;
    logic [11:0] r_batt;
    logic        r_vld;

    logic                      w_wrt;
    logic [SPI_FRAME_BITS-1:0] w_wt_data;
    logic                      w_load;
    logic                      w_done;
    logic [SPI_FRAME_BITS-1:0] w_rd_data;
    logic [2:0]                w_ch;
    logic                      w_unused_rd_hi;

    spi_mnrch u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (w_wrt),
        .wt_data (w_wt_data),
        .done    (w_done),
        .rd_data (w_rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    // The ADC returns a 4-bit header ahead of the 12-bit result
    assign w_unused_rd_hi = &{1'b0, w_rd_data[SPI_FRAME_BITS-1:12]};

    always_comb begin
        w_ch = CH_LFT;
        case (r_rr)
            RR_LFT:   w_ch = CH_LFT;
            RR_RGHT:  w_ch = CH_RGHT;
            RR_STEER: w_ch = CH_STEER;
            RR_BATT:  w_ch = CH_BATT;
            default:  w_ch = CH_LFT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wrt       = 1'b0;
        w_wt_data   = '0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (nxt) begin
                    w_wrt       = 1'b1;
                    w_wt_data   = a2d_cmd(w_ch);
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                if (w_done) begin
                    w_state_nxt = GAP;
                end
            end
            GAP: begin
                w_wrt       = 1'b1;
                w_state_nxt = READ;
            end
            READ: begin
                if (w_done) begin
                    w_load      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr        <= RR_LFT;
            r_lft_ld    <= 12'h000;
            r_rght_ld   <= 12'h000;
            r_steer_pot <= 12'h000;
            r_batt      <= 12'h000;
            r_vld       <= 1'b0;
        end else begin
            r_vld <= w_load;
            if (w_load) begin
                case (r_rr)
                    RR_LFT:   r_lft_ld    <= w_rd_data[11:0];
                    RR_RGHT:  r_rght_ld   <= w_rd_data[11:0];
                    RR_STEER: r_steer_pot <= w_rd_data[11:0];
                    RR_BATT:  r_batt      <= w_rd_data[11:0];
                    default:  r_lft_ld    <= w_rd_data[11:0];
                endcase
                r_rr <= rr_idx_t'(r_rr + 2'd1);
            end
        end
    end

    assign lft_ld    = r_lft_ld;
    assign rght_ld   = r_rght_ld;
    assign steer_pot = r_steer_pot;
    assign batt      = r_batt;
    assign vld       = r_vld;

endmodule
`default_nettype wire

// File: tb/tb_a2d_ld_intf.sv
`default_nettype none
// ============================================================================
// Module      : tb_a2d_ld_intf
// Description : Self-checking bench for a2d_ld_intf with a behavioural ADC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a2d_ld_intf;

    logic        clk = 1'b0;
    logic        rst;
    logic        nxt;
    logic        MISO = 1'b0;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        vld;

    always #10 clk = ~clk;

    a2d_ld_intf dut (
        .clk       (clk),
        .rst       (rst),
        .nxt       (nxt),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .steer_pot (steer_pot),
        .batt      (batt),
        .vld       (vld)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- ADC model (mode 3 slave) ----------------
    logic [11:0] adc_val [8];
    bit          override = 1'b0;
    logic [15:0] tx_sh, rx_sh;
    int          nbits = 0;
    bit          seen_rise = 1'b0;
    logic [2:0]  adc_ch = 3'd0;
    logic        ss_prev = 1'b1;
    logic        sclk_prev = 1'b1;
    int          frames_started = 0;
    int          sclk_falls = 0;
    logic [15:0] mosi_q [$];

    always @(SS_n or SCLK) begin
        if (ss_prev === 1'b1 && SS_n === 1'b0) begin
            frames_started++;
            nbits     = 0;
            seen_rise = 1'b0;
            tx_sh     = override ? 16'hF7FF : {4'h0, adc_val[adc_ch]};
            MISO      = tx_sh[15];
        end else if (ss_prev === 1'b0 && SS_n === 1'b1) begin
            if (nbits == 16) begin
                adc_ch = rx_sh[13:11];
                mosi_q.push_back(rx_sh);
            end
        end else if (SS_n === 1'b0) begin
            if (sclk_prev === 1'b0 && SCLK === 1'b1) begin
                rx_sh     = {rx_sh[14:0], MOSI};
                nbits++;
                seen_rise = 1'b1;
            end else if (sclk_prev === 1'b1 && SCLK === 1'b0) begin
                sclk_falls++;
                if (seen_rise) begin
                    tx_sh = {tx_sh[14:0], 1'b0};
                    MISO  = tx_sh[15];
                end
            end
        end
        ss_prev   = SS_n;
        sclk_prev = SCLK;
    end

    int vld_cnt = 0;
    always @(negedge clk) if (vld === 1'b1) vld_cnt++;

    // ---------------- reference model ----------------
    int          ch_map [4] = '{0, 4, 5, 6};
    logic [11:0] exp_reg [4];
    int          exp_rr;
    int          mosi_rd = 0;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_reg[i] = 12'h000;
        exp_rr  = 0;
        mosi_rd = mosi_q.size();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nxt = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_lft"},   {20'h0, lft_ld},    {20'h0, exp_reg[0]});
        chk({tag, "_rght"},  {20'h0, rght_ld},   {20'h0, exp_reg[1]});
        chk({tag, "_steer"}, {20'h0, steer_pot}, {20'h0, exp_reg[2]});
        chk({tag, "_batt"},  {20'h0, batt},      {20'h0, exp_reg[3]});
    endtask

    // One conversion; poke re-pulses nxt 10 and 600 clk into the transaction
    task automatic conv(input bit poke);
        int          cyc;
        bit          got;
        int          v0;
        int          ch;
        logic [11:0] val;
        logic [15:0] w;
        ch  = ch_map[exp_rr];
        val = override ? 12'h7FF : adc_val[ch];
        v0  = vld_cnt;
        @(negedge clk);
        nxt = 1'b1;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 1200) begin
            @(negedge clk);
            cyc++;
            nxt = poke && (cyc == 10 || cyc == 600);
            if (vld === 1'b1) got = 1'b1;
        end
        nxt = 1'b0;
        chk("vld_seen", {31'h0, got}, 32'd1);
        chk("latency", cyc, 32'd1058);
        exp_reg[exp_rr] = val;
        exp_rr = (exp_rr + 1) % 4;
        check_regs("conv");
        if (mosi_q.size() >= mosi_rd + 2) begin
            w = mosi_q[mosi_rd];
            chk("cmd_word", {16'h0, w}, {16'h0, 2'b00, 3'(ch), 11'h000});
            w = mosi_q[mosi_rd + 1];
            chk("read_word", {16'h0, w}, 32'h0);
            mosi_rd += 2;
        end else begin
            chk("mosi_frames", mosi_q.size() - mosi_rd, 32'd2);
        end
        repeat (5) @(negedge clk);
        chk("vld_count", vld_cnt - v0, 32'd1);
    endtask

    initial begin
        int  idle_bad;
        int  f0, s0, v0, tmo;
        for (int c = 0; c < 8; c++) adc_val[c] = 12'h000;
        rst = 1'b1;
        nxt = 1'b0;

        // 1. reset and idle
        do_reset();
        @(negedge clk);
        chk("rst_ss_n", {31'h0, SS_n}, 32'd1);
        chk("rst_sclk", {31'h0, SCLK}, 32'd1);
        chk("rst_mosi", {31'h0, MOSI}, 32'd0);
        chk("rst_vld",  {31'h0, vld},  32'd0);
        check_regs("rst");
        idle_bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (SS_n !== 1'b1 || SCLK !== 1'b1 || vld !== 1'b0 ||
                lft_ld !== 12'h0 || rght_ld !== 12'h0 || steer_pot !== 12'h0 || batt !== 12'h0)
                idle_bad++;
        end
        chk("idle_stable", idle_bad, 32'd0);

        // 2. single conversion of ch0
        adc_val[0] = 12'h3A5;
        conv(1'b0);

        // 3. full round robin plus wrap
        do_reset();
        adc_val[0] = 12'h111;
        adc_val[4] = 12'h222;
        adc_val[5] = 12'h333;
        adc_val[6] = 12'h444;
        for (int i = 0; i < 5; i++) conv(1'b0);

        // 4. upper nibble of read frame ignored
        do_reset();
        for (int i = 0; i < 3; i++) conv(1'b0);
        override = 1'b1;
        conv(1'b0);
        override = 1'b0;

        // 5. nxt while busy is ignored
        do_reset();
        conv(1'b1);
        conv(1'b0);

        // randomized conversions
        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
            repeat ($urandom_range(0, 20)) @(negedge clk);
            conv(($urandom % 4) == 0);
        end

        // 6. reset in the middle of a READ frame
        f0 = frames_started;
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        tmo = 0;
        while (frames_started < f0 + 2 && tmo < 1200) begin
            @(negedge clk);
            tmo++;
        end
        chk("read_frame_start", frames_started - f0, 32'd2);
        s0  = sclk_falls;
        tmo = 0;
        while (sclk_falls < s0 + 9 && tmo < 400) begin
            @(negedge clk);
            tmo++;
        end
        chk("ninth_sclk", sclk_falls - s0, 32'd9);
        v0  = vld_cnt;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ss_n", {31'h0, SS_n}, 32'd1);
        chk("abort_sclk", {31'h0, SCLK}, 32'd1);
        chk("abort_vld",  {31'h0, vld},  32'd0);
        rst = 1'b0;
        model_reset();
        check_regs("abort");
        repeat (600) @(negedge clk);
        chk("abort_no_vld", vld_cnt - v0, 32'd0);
        check_regs("abort_hold");
        adc_val[0] = 12'hABC;
        conv(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
